// File: rtl/spio_link_pkg.sv
// Shared constants and helpers for the serial LED/segment shift link receivers.
package spio_link_pkg;

   localparam int unsigned LED_FRAME_W      = 16;
   localparam int unsigned SEG_FRAME_W      = 64;
   localparam int unsigned SYNC_STAGES_DFLT = 2;
   // Each s_clk phase must outlast the synchronizer plus the edge-history flop.
   localparam int unsigned MIN_PHASE_CLKS   = SYNC_STAGES_DFLT + 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned min_phase_clks(input int unsigned sync_stages);
      return sync_stages + 1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one link input, plus a history flop for rise detection.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/spio_shift_rx.sv
// Oversampling receiver that rebuilds the parallel word of the serial shift-register chain.
module spio_shift_rx
   import spio_link_pkg::*;
#(
   parameter int unsigned WIDTH       = LED_FRAME_W,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT,
   parameter bit          MSB_FIRST   = 1'b1
) (
   input  logic                          clk,
   input  logic                          RSTN,
   input  logic                          s_clk,
   input  logic                          s_din,
   input  logic                          s_pen,
   input  logic                          s_clrn,
   output logic [WIDTH-1:0]              data_out,
   output logic                          data_valid,
   output logic                          frame_err,
   output logic [clog2(WIDTH+2)-1:0]     bit_cnt
);

   localparam int unsigned CNT_W = clog2(WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

   logic clk_lvl_unused, clk_rise;
   logic pen_lvl_unused, pen_rise;
   logic clrn_lvl, clrn_rise_unused;
   logic din_lvl, din_rise_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk(clk), .rst_n(RSTN), .d(s_clk),  .level(clk_lvl_unused), .rise(clk_rise));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pen (
      .clk(clk), .rst_n(RSTN), .d(s_pen),  .level(pen_lvl_unused), .rise(pen_rise));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clrn (
      .clk(clk), .rst_n(RSTN), .d(s_clrn), .level(clrn_lvl), .rise(clrn_rise_unused));
   // Same depth as s_clk so the sampled bit stays aligned with its shift edge.
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk), .rst_n(RSTN), .d(s_din),  .level(din_lvl), .rise(din_rise_unused));

   logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      sr_shift     = MSB_FIRST ? {sr_q[WIDTH-2:0], din_lvl} : {din_lvl, sr_q[WIDTH-1:1]};
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (!clrn_lvl) begin
         sr_d      = '0;
         bit_cnt_d = '0;
      end else begin
         if (clk_rise) begin
            sr_d      = sr_shift;
            bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
         end
         // Strobe judges the post-shift state so a coincident last bit still counts.
         if (pen_rise) begin
            if (bit_cnt_d == CNT_FULL) begin
               data_out_d   = sr_d;
               data_valid_d = 1'b1;
            end else begin
               frame_err_d  = 1'b1;
            end
            bit_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         sr_q         <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         bit_cnt_q    <= '0;
      end else begin
         sr_q         <= sr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         bit_cnt_q    <= bit_cnt_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign bit_cnt    = bit_cnt_q;

endmodule

// File: doc/spio_shift_rx.md
Name: spio_shift_rx

Overview:
- Receiving end of the serial LED/segment shift link driven by the SPIO and SSeg7_Dev serializers (signals `*_clk`, `*_sout`, `*_PEN`, `*_clrn`).
- Oversamples the link in the board clock domain and rebuilds the parallel word that the on-board shift-register chain would present.
- Used as a board model in simulation and as an on-chip loopback monitor, so the LED/segment path can be checked without hardware.

Parameters:
- WIDTH, 16, bits per frame (16 for the LED chain, 64 for the segment chain).
- SYNC_STAGES, 2, synchronizer flops per link input (≥2).
- MSB_FIRST, 1, 1 = first bit received ends in data_out[WIDTH-1]; 0 = first bit ends in data_out[0].

Ports:
- clk  in  1  board clock (100 MHz); samples the link.
- RSTN  in  1  asynchronous active-low reset.
- s_clk  in  1  serial shift clock from the serializer; async to clk.
- s_din  in  1  serial data; valid at the s_clk rising edge.
- s_pen  in  1  parallel-load strobe; active-high, its rising edge latches the frame.
- s_clrn  in  1  active-low chain clear.
- data_out  out  WIDTH  last good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when a strobe arrives with a bit count ≠ WIDTH.
- bit_cnt  out  clog2(WIDTH+2)  bits shifted since the last strobe or clear; saturates at WIDTH+1.

Behaviour:
- Reset (RSTN=0, asynchronous): data_out=0, data_valid=0, frame_err=0, bit_cnt=0, shift register=0, all synchronizer and edge-history flops=0.
  - Deassertion is sampled by the first clk edge.
- Synchronization:
  - s_clk, s_din, s_pen and s_clrn each pass through SYNC_STAGES flops.
  - One extra history flop on synced s_clk and synced s_pen drives rise detection.
  - s_din is delayed identically, so its alignment with s_clk is preserved.
- Link timing requirement: s_clk high and low phases ≥ SYNC_STAGES+1 clk periods each; faster links are out of spec.
- Priority per clk cycle, highest first:
  1. sclr = synced s_clrn==0: clear shift register, bit_cnt=0, no pulses. Clear level-holds while low and suppresses any s_clk or s_pen edge that cycle.
  2. s_clk rise: shift in synced s_din.
     - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
     - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
     - bit_cnt <= min(bit_cnt+1, WIDTH+1).
  3. s_pen rise: evaluated on the post-shift value, so a same-cycle s_clk rise is included.
     - If count==WIDTH: data_out <= shifted sr; data_valid=1 for exactly one cycle.
     - Otherwise: frame_err=1 for one cycle and data_out holds.
     - In both cases bit_cnt <= 0 next cycle. The shift register is not cleared: a trailing-bit overflow keeps only the last WIDTH bits, but the frame is still flagged.
- Latency: data_valid and data_out update SYNC_STAGES+1 clk cycles after the raw s_pen rising edge.
- Saturation: bit_cnt never wraps. A long burst with no strobe stays at WIDTH+1 until the next strobe or clear.
- s_pen held high: only one latch per rising edge; repeated high cycles do nothing.
- RSTN asserted mid-frame: all state is lost immediately. After release, the partial frame is absent and the next strobe gives frame_err unless a full WIDTH bits follow.
- data_valid and frame_err are never both 1 in the same cycle.

Decomposition:
- Shared package spio_link_pkg:
  - LED_FRAME_W=16, SEG_FRAME_W=64.
  - Function clog2.
  - Link timing constant MIN_PHASE_CLKS=SYNC_STAGES+1.
- One sub-module, sync_edge: parameterized SYNC_STAGES synchronizer plus history flop.
  - Outputs: level, rise.
  - Instantiated for s_clk, s_pen, s_clrn; s_din uses level only.

Test Plan:
- Reset, WIDTH=16, MSB_FIRST=1: shift 0xA5C3 MSB first, s_clk phases of 4 clk, then pulse s_pen → data_out=0xA5C3, one data_valid pulse exactly 3 clk after the raw s_pen rise, bit_cnt returns to 0.
- Shift 15 bits, then s_pen → frame_err pulse, data_out keeps its previous value, no data_valid. Shift 20 bits, then s_pen → bit_cnt reads 17 before the strobe, then frame_err.
- 10 bits shifted, then s_clrn low for 5 clk, then 16 bits of 0x00FF and s_pen → data_out=0x00FF, data_valid.
- Last (16th) s_clk rise and s_pen rise aligned to the same clk cycle → 16-bit frame accepted, data_valid asserted, no frame_err.
- MSB_FIRST=0, WIDTH=64: shift 64 bits of 0x0123456789ABCDEF, bit 0 first → data_out=0x0123456789ABCDEF.
- RSTN pulsed low after 8 of 16 bits, then 8 more bits and s_pen → all outputs 0 during reset, then frame_err (count 8).
